color_pack_writer: RTL and testbench
====================================

Name: color_pack_writer

Overview:
- Write-side counterpart to the colour shift cache in the memory subsystem.
- Accepts processed 8-bit RGB pixels from the filter datapath and packs two consecutive pixels into three 16-bit words, one per channel.
- Writes those words to data memory through a single-port, stallable write interface.
- Word layout per channel: first pixel in bits [15:8], second pixel in bits [7:0], matching the read-side byte order.

Parameters:
ADDR_W, 16, width of memory word address and write pointer
CH_N, 3, number of colour channels; words written per pixel pair

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; loads base_addr and arms block
base_addr  in  ADDR_W  first word address of output buffer
px_valid  in  1  pixel valid
px_in  in  CH_N x 8  pixel bytes, index 0=R, 1=G, 2=B
px_ready  out  1  block can accept pixel this cycle
flush  in  1  one-cycle pulse; write out any held half pair
flush_done  out  1  one-cycle pulse when flush fully drained
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word address
mem_do  out  16  write data
mem_ready  in  1  memory accepts write this cycle
busy  out  1  high outside IDLE
pix_count  out  16  accepted-pixel count (optional feature)

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, pointer 0, half flag 0, flush pending 0.
- Pixel transfer: occurs on px_valid & px_ready at a clock edge.
- Write transfer: occurs on mem_we & mem_ready. mem_addr and mem_do stay stable while mem_we=1 and mem_ready=0.
- IDLE:
  - px_ready=0.
  - start: ptr<=base_addr, go to COLLECT.
  - flush: pulse flush_done next cycle.
- COLLECT:
  - px_ready=1.
  - First pixel: hi[c]<=px_in[c], half<=1.
  - Second pixel: lo[c]<=px_in[c], half<=0, go to WRITE with ch=0.
- WRITE:
  - px_ready=0, mem_we=1, mem_addr=ptr, mem_do={hi[ch],lo[ch]}.
  - Each write transfer: ptr<=ptr+1, ch<=ch+1.
  - After ch=CH_N-1 transfers: go to COLLECT, or go to IDLE with flush_done pulse if flush is pending.
- Write pointer wraps mod 2^ADDR_W.
- Latency: first mem_we is asserted the cycle after the second pixel transfer. With mem_ready=1, a pair drains in exactly CH_N cycles.
- Flush:
  - flush sets flush_pend; it is evaluated after a pixel transfer in the same cycle.
  - COLLECT, half=1: lo<=0 (zero pad), go to WRITE.
  - COLLECT, half=0: flush_done pulses next cycle, return to IDLE.
  - Flush arriving during WRITE stays pending and is honoured at the end of the pair.
- start while busy is ignored, except in COLLECT with half=0 and no flush pending. In that case ptr reloads.
- flush_done is exactly one cycle wide.

Optional Feature:
- Macro: COLOR_PACK_CNT_EN.
- Defined: pix_count increments by 1 per pixel transfer, clears on accepted start, and saturates at 16'hFFFF.
- Undefined: pix_count is constant 0 and no counter flops are built.

Decomposition:
- Package color_pack_pkg holds:
  - state enum (IDLE, COLLECT, WRITE)
  - CH_N default constant
  - channel index constants (CH_R=0, CH_G=1, CH_B=2)
- One sub-module, color_pair_reg: holds the hi/lo byte arrays with load-hi, load-lo and zero-lo controls. FSM, pointer and handshake stay in the top level.

Test Plan:
- Basic pair: start, base_addr=0x0100; pixels {R,G,B}={0x11,0x22,0x33},{0x44,0x55,0x66}; mem_ready=1 -> writes 0x0100:0x1144, 0x0101:0x2255, 0x0102:0x3366 on 3 consecutive cycles; px_ready=0 during those cycles.
- Stall: same stimulus with mem_ready low for 2 cycles on the second write -> mem_addr=0x0101 and mem_do=0x2255 held stable, no ptr advance, final ptr=0x0103.
- Odd flush: one pixel {0xAA,0xBB,0xCC}, then flush -> writes 0xAA00, 0xBB00, 0xCC00, then single-cycle flush_done, busy=0.
- Empty flush and wrap: base_addr=0xFFFF, one full pair -> addresses 0xFFFF, 0x0000, 0x0001; a following flush -> flush_done next cycle with no writes.
- Reset mid-write: rst low during WRITE ch=1 -> mem_we=0 and busy=0 immediately; after release, no write until new start.
- COLOR_PACK_CNT_EN: 5 pixels then start -> pix_count reads 5, then 0 after start; without the macro, reads 0 throughout.

Source files
------------

// File: rtl/color_pack_pkg.sv
// Shared types and constants for the colour pair writer.
// Build option: define COLOR_PACK_CNT_EN to enable the accepted-pixel counter.
package color_pack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } state_e;

  localparam int CH_N_DEF = 3;
  localparam int CH_R     = 0;
  localparam int CH_G     = 1;
  localparam int CH_B     = 2;

  // Channel index width; at least one bit so a single-channel build still has a counter.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/color_pack_writer_pair_reg.sv
// Holds the first (hi) and second (lo) pixel bytes of a pair and presents
// the packed {hi,lo} word for the selected channel.
module color_pair_reg
  import color_pack_pkg::*;
#(
  parameter int CH_N = CH_N_DEF,
  parameter int CH_W = ch_w(CH_N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_hi,
  input  logic                 load_lo,
  input  logic                 zero_lo,
  input  logic [CH_N-1:0][7:0] px_in,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [15:0]          rd_word
);

  logic [CH_N-1:0][7:0] hi_q, hi_d;
  logic [CH_N-1:0][7:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_hi) hi_d = px_in;
    // Zero pad wins so a flushed half pair never carries stale bytes.
    if (zero_lo)      lo_d = '0;
    else if (load_lo) lo_d = px_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < CH_N; c++) begin
      if (rd_ch == CH_W'(c)) rd_word = {hi_q[c], lo_q[c]};
    end
  end

endmodule

// File: rtl/color_pack_writer.sv
// Packs pixel pairs into one 16-bit word per channel and writes them through
// a stallable memory port. Build option: COLOR_PACK_CNT_EN adds pix_count.
module color_pack_writer
  import color_pack_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CH_N   = CH_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 px_valid,
  input  logic [CH_N-1:0][7:0] px_in,
  output logic                 px_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [15:0]          mem_do,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic [15:0]          pix_count,
  output state_e               dbg_state
);

  // Handshakes: a pixel moves on px_valid & px_ready at a rising edge; a word
  // moves on mem_we & mem_ready. While mem_we is high and mem_ready low, the
  // address and data are held unchanged.

  localparam int CH_W = ch_w(CH_N);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                half_q, half_d;
  logic                flush_pend_q, flush_pend_d;
  logic                flush_done_q, flush_done_d;
  logic                load_hi, load_lo, zero_lo;
  logic                px_fire, wr_fire, flush_eff, last_ch;
  logic [15:0]         pair_word;

  assign px_fire   = px_valid & px_ready;
  assign wr_fire   = mem_we & mem_ready;
  assign flush_eff = flush | flush_pend_q;
  assign last_ch   = (ch_q == CH_W'(CH_N - 1));

  color_pair_reg #(.CH_N(CH_N), .CH_W(CH_W)) u_pair (
    .clk     (clk),
    .rst     (rst),
    .load_hi (load_hi),
    .load_lo (load_lo),
    .zero_lo (zero_lo),
    .px_in   (px_in),
    .rd_ch   (ch_q),
    .rd_word (pair_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      ch_q         <= '0;
      half_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ch_q         <= ch_d;
      half_q       <= half_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ch_d         = ch_q;
    half_d       = half_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    load_hi      = 1'b0;
    load_lo      = 1'b0;
    zero_lo      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) flush_done_d = 1'b1;
        if (start) begin
          ptr_d        = base_addr;
          half_d       = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = COLLECT;
        end
      end
      COLLECT: begin
        if (start && !half_q && !flush_eff) ptr_d = base_addr;
        // The pixel is applied first, then any flush sees the updated half flag.
        if (px_fire && half_q) begin
          load_lo      = 1'b1;
          half_d       = 1'b0;
          ch_d         = '0;
          flush_pend_d = flush_eff;
          state_d      = WRITE;
        end else if (flush_eff) begin
          if (px_fire || half_q) begin
            load_hi      = px_fire;
            zero_lo      = 1'b1;
            half_d       = 1'b0;
            ch_d         = '0;
            flush_pend_d = 1'b1;
            state_d      = WRITE;
          end else begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end else if (px_fire) begin
          load_hi = 1'b1;
          half_d  = 1'b1;
        end
      end
      WRITE: begin
        if (flush) flush_pend_d = 1'b1;
        if (wr_fire) begin
          ptr_d = ptr_q + ADDR_W'(1);
          ch_d  = ch_q + CH_W'(1);
          if (last_ch) begin
            ch_d = '0;
            if (flush_eff) begin
              flush_done_d = 1'b1;
              flush_pend_d = 1'b0;
              state_d      = IDLE;
            end else begin
              state_d = COLLECT;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    px_ready   = (state_q == COLLECT);
    mem_we     = (state_q == WRITE);
    mem_addr   = mem_we ? ptr_q : '0;
    mem_do     = mem_we ? pair_word : '0;
    busy       = (state_q != IDLE);
    flush_done = flush_done_q;
    dbg_state  = state_q;
  end

`ifdef COLOR_PACK_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        start_ok;

  assign start_ok = start && ((state_q == IDLE) ||
                    (state_q == COLLECT && !half_q && !flush_eff));

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)                        cnt_d = '0;
    else if (px_fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pix_count = cnt_q;
`else
  assign pix_count = '0;
`endif

endmodule

// File: tb/tb_color_pack_writer.sv
// Directed bench for color_pack_writer: vector table plus reset, counter and flush sequences.
module tb_color_pack_writer;
  import color_pack_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       base_addr;
  logic              px_valid;
  logic [2:0][7:0]   px_in;
  logic              px_ready;
  logic              flush;
  logic              flush_done;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_do;
  logic              mem_ready;
  logic              busy;
  logic [15:0]       pix_count;
  state_e            dbg_state;

  color_pack_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .px_valid   (px_valid),
    .px_in      (px_in),
    .px_ready   (px_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_do     (mem_do),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .pix_count  (pix_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic [15:0] base;
    logic        pv;
    logic [23:0] rgb;
    logic        fl;
    logic        mr;
    logic        e_pr;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_do;
    logic        e_busy;
    logic        e_fd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, input logic [15:0] base, input logic pv,
                              input logic [23:0] rgb, input logic fl, input logic mr,
                              input logic e_pr, input logic e_we, input logic [15:0] e_addr,
                              input logic [15:0] e_do, input logic e_busy, input logic e_fd);
    vec_t v;
    v.st = st; v.base = base; v.pv = pv; v.rgb = rgb; v.fl = fl; v.mr = mr;
    v.e_pr = e_pr; v.e_we = e_we; v.e_addr = e_addr; v.e_do = e_do;
    v.e_busy = e_busy; v.e_fd = e_fd;
    return v;
  endfunction

  // driver tasks
  task automatic set_px(input logic [23:0] rgb);
    px_in[CH_R] = rgb[23:16];
    px_in[CH_G] = rgb[15:8];
    px_in[CH_B] = rgb[7:0];
  endtask

  task automatic clear_inputs();
    start = 1'b0; base_addr = '0; px_valid = 1'b0; px_in = '0;
    flush = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    @(negedge clk);
    start = v.st; base_addr = v.base; px_valid = v.pv; set_px(v.rgb);
    flush = v.fl; mem_ready = v.mr;
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_px_ready"}, 32'(px_ready), 32'(v.e_pr));
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(v.e_we));
    chk({tag, "_busy"}, 32'(busy), 32'(v.e_busy));
    chk({tag, "_flush_done"}, 32'(flush_done), 32'(v.e_fd));
    if (v.e_we) begin
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
      chk({tag, "_mem_do"}, 32'(mem_do), 32'(v.e_do));
    end
  endtask

  task automatic send_px(input logic [23:0] rgb);
    bit got = 0;
    px_valid = 1'b1;
    set_px(rgb);
    for (int i = 0; i < 20; i++) begin
      if (px_ready) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("px_ready_wait", 32'(got), 32'd1);
    @(negedge clk);
    px_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // scoreboard: {addr, data} of every expected write while mon_en is set
  logic [31:0] exp_q[$];
  bit          mon_en = 0;

  always begin
    @(negedge clk);
    #2;
    if (mon_en && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", {mem_addr, mem_do}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_write", {mem_addr, mem_do}, exp_q.pop_front());
      end
    end
  end

  logic [23:0] pix[5];
  logic [15:0] exp_cnt;

  initial begin
    rst = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_px_ready", 32'(px_ready), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_do", 32'(mem_do), 32'd0);
    chk("rst_pix_count", 32'(pix_count), 32'd0);
    rst = 1'b1;

    //          st base     pv rgb        fl mr  pr we addr     do       busy fd
    tv.push_back(mk(1, 16'h0100, 0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h112233, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h445566, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0100, 16'h1144, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0101, 16'h2255, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0102, 16'h3366, 1, 0));
    // start in COLLECT with no half pair reloads the pointer
    tv.push_back(mk(1, 16'h0100, 0, 24'h0,      0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h112233, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h445566, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0100, 16'h1144, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 0,  0, 1, 16'h0101, 16'h2255, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 0,  0, 1, 16'h0101, 16'h2255, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0101, 16'h2255, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0102, 16'h3366, 1, 0));
    // odd flush continues from pointer 0x0103
    tv.push_back(mk(0, 16'h0,    1, 24'hAABBCC, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      1, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0103, 16'hAA00, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0104, 16'hBB00, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0105, 16'hCC00, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 1));
    // pointer wrap, then empty flush
    tv.push_back(mk(1, 16'hFFFF, 0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h010203, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h040506, 0, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'hFFFF, 16'h0104, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0000, 16'h0205, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0001, 16'h0306, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      1, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 1));
    // flush in IDLE
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      1, 1,  0, 0, 16'h0,    16'h0,    0, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 1));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 0));
    // pixel and flush in the same cycle: pixel becomes a padded half pair
    tv.push_back(mk(1, 16'h0300, 0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 0));
    tv.push_back(mk(0, 16'h0,    1, 24'h778899, 1, 1,  1, 0, 16'h0,    16'h0,    1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0300, 16'h7700, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0301, 16'h8800, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 1, 16'h0302, 16'h9900, 1, 0));
    tv.push_back(mk(0, 16'h0,    0, 24'h0,      0, 1,  0, 0, 16'h0,    16'h0,    0, 1));

    for (int i = 0; i < tv.size(); i++) apply_vec(i, tv[i]);

    // reset in the middle of a write burst
    @(negedge clk);
    clear_inputs();
    start = 1'b1; base_addr = 16'h0400;
    @(negedge clk); start = 1'b0;
    px_valid = 1'b1; set_px(24'h010101);
    @(negedge clk); set_px(24'h020202);
    @(negedge clk); px_valid = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_we_ch1", 32'(mem_we), 32'd1);
    chk("rstmid_addr_ch1", 32'(mem_addr), 32'h0401);
    rst = 1'b0;
    #1;
    chk("rstmid_mem_we", 32'(mem_we), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    px_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rstmid_idle_we%0d", i), 32'(mem_we), 32'd0);
      chk($sformatf("rstmid_idle_pr%0d", i), 32'(px_ready), 32'd0);
    end
    px_valid = 1'b0;

    // counter and scoreboarded writes: 5 pixels, flush, then start
    do_reset();
    for (int i = 0; i < 5; i++) pix[i] = {8'h11 + 8'(i), 8'h21 + 8'(i), 8'h31 + 8'(i)};
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back({16'h0200 + 16'(p * 3 + c),
                         pix[2*p][23-8*c -: 8], pix[2*p+1][23-8*c -: 8]});
      end
    end
    for (int c = 0; c < 3; c++) exp_q.push_back({16'h0206 + 16'(c), pix[4][23-8*c -: 8], 8'h00});
    mon_en = 1;
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0200;
    @(negedge clk);
    start = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) send_px(pix[i]);
`ifdef COLOR_PACK_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    chk("cnt_after_5", 32'(pix_count), 32'(exp_cnt));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    begin
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (flush_done) begin got = 1; break; end
        @(negedge clk);
      end
      chk("cnt_flush_done_wait", 32'(got), 32'd1);
    end
    chk("cnt_before_start", 32'(pix_count), 32'(exp_cnt));
    @(negedge clk);
    start = 1'b1; base_addr = 16'h0500;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("cnt_after_start", 32'(pix_count), 32'd0);
    chk("cnt_busy_after_start", 32'(busy), 32'd1);
    mon_en = 0;
    chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
